// File: rtl/ram_sdp_stream.sv
// Simple-dual-port RAM with a free-running write port and a credit-limited valid/ready read stream.
// Define RAM_SDP_STREAM_WRITE_FIRST_EN for write-first same-address collisions (read-first otherwise).
module ram_sdp_stream #(
    parameter int    DWIDTH    = 18,
    parameter int    AWIDTH    = 10,
    parameter int    DEPTH     = 2**AWIDTH,
    parameter int    RD_LAT    = 2,
    parameter string RAM_STYLE = "auto"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [AWIDTH-1:0] raddr,
    output logic              rdq_valid,
    input  logic              rdq_ready,
    output logic [DWIDTH-1:0] rdq
);

    localparam int BUF_N = RD_LAT + 1;
    localparam int PW    = $clog2(BUF_N);
    localparam int CW    = $clog2(BUF_N + 1);
    localparam logic [CW-1:0]     BUF_FULL = CW'(BUF_N);
    localparam logic [PW-1:0]     PTR_LAST = PW'(BUF_N - 1);
    localparam logic [AWIDTH:0]   DEPTH_C  = (AWIDTH + 1)'(DEPTH);

    (* ram_style = RAM_STYLE *) logic [DWIDTH-1:0] mem [DEPTH];

    logic              waddr_ok, raddr_ok;
    logic              accept, pop;
    logic [DWIDTH-1:0] rd_word;
    logic [RD_LAT-1:0] s_valid;
    logic [DWIDTH-1:0] s_data [RD_LAT];
    logic              pipe_valid;
    logic [DWIDTH-1:0] pipe_data;
    logic [DWIDTH-1:0] fifo_mem [BUF_N];
    logic [PW-1:0]     rptr, wptr;
    logic [CW-1:0]     count, occ, occ_next;
    logic              buf_empty, buf_push, buf_pop;

    assign waddr_ok   = {1'b0, waddr} < DEPTH_C;
    assign raddr_ok   = {1'b0, raddr} < DEPTH_C;
    assign accept     = rd_valid && rd_ready;
    assign pipe_valid = s_valid[RD_LAT-1];
    assign pipe_data  = s_data[RD_LAT-1];
    assign buf_empty  = (count == '0);
    assign rdq_valid  = !buf_empty || pipe_valid;
    assign rdq        = buf_empty ? pipe_data : fifo_mem[rptr];
    assign pop        = rdq_valid && rdq_ready;
    assign buf_pop    = !buf_empty && rdq_ready;
    // A result emerging into an empty buffer that is consumed at once never gets stored.
    assign buf_push   = pipe_valid && !(buf_empty && rdq_ready);

    always_ff @(posedge clk) begin
        if (rst_n && wen && waddr_ok)
            mem[waddr] <= wdata;
    end

    always_comb begin
        rd_word = raddr_ok ? mem[raddr] : '0;
`ifdef RAM_SDP_STREAM_WRITE_FIRST_EN
        if (wen && waddr_ok && (waddr == raddr))
            rd_word = wdata;
`endif
    end

    // The pipeline never stalls; occupancy credits guarantee buffer space for every result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= '0;
            for (int i = 0; i < RD_LAT; i++)
                s_data[i] <= '0;
        end else begin
            s_valid[0] <= accept;
            if (accept)
                s_data[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_data[i]  <= s_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_push)
            fifo_mem[wptr] <= pipe_data;
    end

    always_comb begin
        occ_next = occ;
        if (accept && !pop)
            occ_next = occ + 1'b1;
        else if (!accept && pop)
            occ_next = occ - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rptr     <= '0;
            wptr     <= '0;
            occ      <= '0;
            rd_ready <= 1'b0;
        end else begin
            occ      <= occ_next;
            rd_ready <= (occ_next < BUF_FULL);
            if (buf_push)
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (buf_pop)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            case ({buf_push, buf_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sdp_stream.sv
// Self-checking bench for ram_sdp_stream: vector table, directed corner sequences and a randomized phase
// checked against a memory-array/response-queue reference model.
module tb_ram_sdp_stream;

    localparam int DW    = 18;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int LAT   = 2;
`ifdef RAM_SDP_STREAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] raddr = '0;
    logic          rdq_valid;
    logic          rdq_ready = 1'b0;
    logic [DW-1:0] rdq;

    ram_sdp_stream #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .RD_LAT(LAT), .RAM_STYLE("auto")) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .raddr(raddr),
        .rdq_valid(rdq_valid), .rdq_ready(rdq_ready), .rdq(rdq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            known;
        logic [DW-1:0] val;
    } exp_t;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          qr;
        logic          e_ready;
        logic          e_valid;
        logic [DW-1:0] e_rdq;
    } vec_t;

    logic [DW-1:0] mdl [1024];
    bit            known [1024];
    exp_t          expq [$];
    int            outstanding = 0;
    bit            exp_rd_ready = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_rdq = '0;
    logic          s_ready, s_valid;
    logic [DW-1:0] s_rdq;
    int            errors = 0;
    int            checks = 0;
    vec_t          tbl [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, update the model across the rising edge.
    task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic rv, input logic [AW-1:0] ra, input logic qr);
        bit   acc, pp;
        exp_t e;
        wen = w; waddr = wa; wdata = wd; rd_valid = rv; raddr = ra; rdq_ready = qr;
        #1;
        s_ready = rd_ready; s_valid = rdq_valid; s_rdq = rdq;
        checkOutput("rd_ready", {31'b0, s_ready}, {31'b0, exp_rd_ready});
        if (outstanding == 0)
            checkOutput("idle_rdq_valid", {31'b0, s_valid}, 32'd0);
        if (prev_hold) begin
            checkOutput("hold_rdq_valid", {31'b0, s_valid}, 32'd1);
            checkOutput("hold_rdq", {14'b0, s_rdq}, {14'b0, prev_rdq});
        end
        acc = rv && s_ready;
        pp  = s_valid && qr;
        if (pp) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_response: got 0x%0h expected no response", s_rdq);
            end else begin
                e = expq.pop_front();
                if (e.known)
                    checkOutput("rdq_data", {14'b0, s_rdq}, {14'b0, e.val});
            end
        end
        if (acc) begin
            e.known = ({22'b0, ra} < DEPTH) && known[ra];
            e.val   = mdl[ra];
            if (WF && w && (wa == ra) && ({22'b0, ra} < DEPTH)) begin
                e.known = 1'b1;
                e.val   = wd;
            end
            expq.push_back(e);
        end
        if (w && ({22'b0, wa} < DEPTH)) begin
            mdl[wa]   = wd;
            known[wa] = 1'b1;
        end
        prev_hold   = s_valid && !qr;
        prev_rdq    = s_rdq;
        outstanding = outstanding + (acc ? 1 : 0) - (pp ? 1 : 0);
        @(posedge clk);
        exp_rd_ready = (outstanding < LAT + 1);
        #1;
        wen = 1'b0; rd_valid = 1'b0; rdq_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain_expect(input string name, input logic [DW-1:0] expv);
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
            if (s_valid) begin
                got = 1'b1;
                checkOutput(name, {14'b0, s_rdq}, {14'b0, expv});
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no response expected 0x%0h", name, expv);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0)
            return AW'($urandom_range(995, 1023));
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        int nb;
        //            w     wa      wd        rv    ra      qr    rdy   vld   rdq
        tbl[0]  = '{1'b1, 10'd5, 18'h2A,  1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[1]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd5, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[2]  = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[3]  = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 18'h2A};
        tbl[4]  = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 18'h0};
        tbl[5]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd0, 1'b0, 1'b1, 1'b0, 18'h0};
        tbl[6]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 18'h0};
        tbl[7]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd2, 1'b0, 1'b1, 1'b1, 18'h100};
        tbl[8]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 18'h100};
        tbl[9]  = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 18'h100};
        tbl[10] = '{1'b0, 10'd0, 18'h0,   1'b1, 10'd3, 1'b1, 1'b0, 1'b1, 18'h100};
        tbl[11] = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 18'h101};
        tbl[12] = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b1, 18'h102};
        tbl[13] = '{1'b0, 10'd0, 18'h0,   1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 18'h0};
        for (int i = 0; i < 1024; i++) begin
            mdl[i]   = '0;
            known[i] = 1'b0;
        end

        #12;
        checkOutput("reset_rd_ready", {31'b0, rd_ready}, 32'd0);
        checkOutput("reset_rdq_valid", {31'b0, rdq_valid}, 32'd0);
        checkOutput("reset_rdq", {14'b0, rdq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Single read latency, then the full-backpressure sequence, both from the table.
        for (int i = 0; i < 14; i++) begin
            if (i == 5) begin
                for (int a = 0; a < 8; a++)
                    applyStimulus(1'b1, AW'(a), DW'(32'h100 + a), 1'b0, '0, 1'b1);
                nb = 0;
                for (int j = 0; j < 14; j++) begin
                    applyStimulus(1'b0, '0, '0, j < 8, AW'(j), 1'b1);
                    if (s_valid) begin
                        checkOutput("burst_beat", {14'b0, s_rdq}, 32'h100 + nb);
                        nb++;
                    end else if (nb > 0 && nb < 8) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL burst_gap: got idle cycle after %0d beats expected 8 consecutive", nb);
                    end
                end
                checkOutput("burst_count", nb, 32'd8);
            end
            applyStimulus(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].qr);
            checkOutput($sformatf("vec%0d_rd_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].e_ready});
            checkOutput($sformatf("vec%0d_rdq_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid)
                checkOutput($sformatf("vec%0d_rdq", i), {14'b0, s_rdq}, {14'b0, tbl[i].e_rdq});
        end

        // Same-cycle write and read of one address.
        applyStimulus(1'b1, 10'd3, 18'h11, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 10'd3, 18'h22, 1'b1, 10'd3, 1'b1);
        drain_expect("collision", WF ? 18'h22 : 18'h11);

        // Top of a non-power-of-two depth and an ignored out-of-range write.
        applyStimulus(1'b1, 10'd999, 18'h3FFFF, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd999, 1'b1);
        drain_expect("addr_999", 18'h3FFFF);
        applyStimulus(1'b1, 10'd1000, 18'h1555, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd1000, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd999, 1'b1);
        drain_expect("oob_keeps_999", 18'h3FFFF);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd0, 1'b1);
        drain_expect("oob_keeps_0", 18'h100);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd7, 1'b1);
        drain_expect("oob_keeps_7", 18'h107);

        // Asynchronous reset with two reads in flight.
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd5, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd5, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rdq_valid", {31'b0, rdq_valid}, 32'd0);
        checkOutput("async_reset_rd_ready", {31'b0, rd_ready}, 32'd0);
        expq.delete();
        outstanding  = 0;
        exp_rd_ready = 1'b0;
        prev_hold    = 1'b0;
        wen = 1'b1; waddr = 10'd5; wdata = 18'h3;
        @(posedge clk);
        #1 wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 10'd5, 1'b1);
        drain_expect("post_reset_read", 18'h105);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), rnd_addr(), DW'($urandom), 1'($urandom_range(0, 1)),
                          rnd_addr(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkOutput("final_outstanding", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
